encoder_emulator: RTL

ENCODER_EMULATOR -- requirements
Module: encoder_emulator

---
 rtl/encoder_emulator_if.sv | 23 ++
 rtl/encoder_emulator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/encoder_emulator_if.sv
// -----------------------------------------------------------------------------
// encoder_emulator_if
// Bus strobes of the multiplexed address/data interface of encoder_emulator.
// The shared ad bus is a bidirectional net and is carried as a plain inout
// port on the design, next to this interface.
//
// Signals:
//   ale  address latch enable, active high
//   rd   read strobe, active low
//   wr   write strobe, active low
//
// Modports:
//   master  bus host (drives the strobes)
//   slave   encoder_emulator (samples the strobes)
// -----------------------------------------------------------------------------
interface encoder_emulator_if;
    logic ale;
    logic rd;
    logic wr;

    modport master (output ale, output rd, output wr);
    modport slave  (input  ale, input  rd, input  wr);
endinterface

// File: rtl/encoder_emulator.sv
// -----------------------------------------------------------------------------
// encoder_emulator
// Two-channel quadrature encoder emulator behind a multiplexed 8-bit
// address/data bus. Software writes signed step requests and a per-channel
// step period; each channel emits one quadrature step every 'period' clocks
// until its pending step count reaches zero.
//
// Ports:
//   clk  in     system clock, all state on the rising edge
//   rst  in     asynchronous reset, active low
//   bus  slave  ale / rd (active low) / wr (active low) strobes
//   ad   inout  multiplexed address/data bus, driven only during reads
//   q0   out    quadrature output, channel 0
//   q1   out    quadrature output, channel 1
//
// Register map (address latched from ad[2:0] while ale is high):
//   0 ch0 position (rd) / step request (wr)   1 ch0 period
//   2 ch1 position (rd) / step request (wr)   3 ch1 period
//   4..7 read 8'h00, writes ignored
// -----------------------------------------------------------------------------
module encoder_emulator #(
    parameter logic [7:0] period_reset = 8'd32
) (
    input  logic                  clk,
    input  logic                  rst,
    encoder_emulator_if.slave     bus,
    inout  wire  [7:0]            ad,
    output logic [1:0]            q0,
    output logic [1:0]            q1
);

    // Bus front end
    logic [2:0]         r_addr;
    logic               r_wr_q;
    logic               r_rd_q;
    logic [7:0]         r_rdata;
    logic               w_wr_evt;
    logic               w_rd_evt;
    logic [7:0]         w_rd_mux;

    // Per-channel state
    logic [7:0]         r_pos  [2];
    logic signed [15:0] r_pend [2];
    logic [7:0]         r_per  [2];
    logic [7:0]         r_tmr  [2];

    // Per-channel next state
    logic               w_step_wr [2];
    logic               w_per_wr  [2];
    logic               w_step    [2];
    logic signed [1:0]  w_dir     [2];
    logic signed [17:0] w_sum     [2];
    logic signed [15:0] w_pend_nx [2];
    logic [7:0]         w_pos_nx  [2];
    logic [7:0]         w_tmr_nx  [2];

    // Clamp the widened pending sum back into the 16-bit signed range.
    function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
        if (v > 18'sd32767)
            return 16'sh7FFF;
        else if (v < -18'sd32768)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    // Edge detect on the sampled strobes: one event per low pulse.
    assign w_wr_evt = r_wr_q & ~bus.wr;
    assign w_rd_evt = r_rd_q & ~bus.rd;

    // The bus is released one clock after rd is sampled high again.
    assign ad = r_rd_q ? 8'hzz : r_rdata;

    always_comb begin
        w_rd_mux = 8'h00;
        case (r_addr)
            3'd0:    w_rd_mux = r_pos[0];
            3'd1:    w_rd_mux = r_per[0];
            3'd2:    w_rd_mux = r_pos[1];
            3'd3:    w_rd_mux = r_per[1];
            default: w_rd_mux = 8'h00;
        endcase
    end

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            w_step_wr[ch] = w_wr_evt && (r_addr == 3'(2 * ch));
            w_per_wr[ch]  = w_wr_evt && (r_addr == 3'(2 * ch + 1));
            w_step[ch]    = (r_tmr[ch] == 8'd0) && (r_pend[ch] != 16'sd0);

            w_dir[ch] = 2'sd0;
            if (w_step[ch])
                w_dir[ch] = r_pend[ch][15] ? -2'sd1 : 2'sd1;

            // A step and a new request in the same cycle both land here.
            w_sum[ch] = 18'(r_pend[ch]) - 18'(w_dir[ch])
                      + (w_step_wr[ch] ? 18'($signed(ad)) : 18'sd0);
            w_pend_nx[ch] = sat16(w_sum[ch]);

            w_pos_nx[ch] = r_pos[ch] + 8'(w_dir[ch]);

            // Period 0 behaves as period 1: reload with zero.
            if (w_step[ch])
                w_tmr_nx[ch] = (r_per[ch] == 8'd0) ? 8'd0 : r_per[ch] - 8'd1;
            else if (r_tmr[ch] != 8'd0)
                w_tmr_nx[ch] = r_tmr[ch] - 8'd1;
            else
                w_tmr_nx[ch] = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= 3'd0;
            r_wr_q  <= 1'b1;
            r_rd_q  <= 1'b1;
            r_rdata <= 8'h00;
            q0      <= 2'b00;
            q1      <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                r_pos[ch]  <= 8'd0;
                r_pend[ch] <= 16'sd0;
                r_per[ch]  <= period_reset;
                r_tmr[ch]  <= 8'd0;
            end
        end else begin
            if (bus.ale)
                r_addr <= ad[2:0];
            r_wr_q <= bus.wr;
            r_rd_q <= bus.rd;
            // Snapshot once per read pulse so the bus value stays stable.
            if (w_rd_evt)
                r_rdata <= w_rd_mux;
            for (int ch = 0; ch < 2; ch++) begin
                r_pos[ch]  <= w_pos_nx[ch];
                r_pend[ch] <= w_pend_nx[ch];
                r_tmr[ch]  <= w_tmr_nx[ch];
                if (w_per_wr[ch])
                    r_per[ch] <= ad;
            end
            // Gray-coded from the next position so q tracks the step edge.
            q0 <= {w_pos_nx[0][1], w_pos_nx[0][1] ^ w_pos_nx[0][0]};
            q1 <= {w_pos_nx[1][1], w_pos_nx[1][1] ^ w_pos_nx[1][0]};
        end
    end

endmodule
